cpu_instr_sequencer: RTL and testbench
======================================

// Module: cpu_instr_sequencer
// PURPOSE
//   Upstream stage of the 512-bit vector CPU. Holds a small program of 9-bit instructions
//   ({op[1:0], reg[1:0], addr[4:0]}). On a start pulse it issues the program to the CPU,
//   one instruction per cycle, repeating it a programmed number of times.
//   The CPU has no NOP encoding, so top level uses instr_valid as the CPU clock-enable.
// PARAMETERS
//   DEPTH      32      program store depth (instructions)
//   AW         5       program address width, clog2(DEPTH)
//   IW         9       instruction width (matches CPU instruction port)
//   IDLE_INSTR 9'h000  value driven on instruction whenever instr_valid=0
// PORTS
//   clk         in   1     single clock, rising edge
//   rst_n       in   1     asynchronous, active-low reset
//   load_en     in   1     write load_data into program store at load_addr (IDLE only)
//   load_addr   in   AW    program store write address
//   load_data   in   IW    instruction to store
//   prog_len    in   AW+1  instructions per pass; sampled at start
//   repeat_cnt  in   8     extra passes; total passes = repeat_cnt+1; sampled at start
//   start       in   1     begin issuing (IDLE only)
//   pause       in   1     level; hold issue while high
//   abort       in   1     return to IDLE immediately; no done pulse
//   instruction out  IW    registered instruction to CPU
//   instr_valid out  1     instruction is live this cycle
//   pc          out  AW    index of next instruction to fetch
//   busy        out  1     state != IDLE
//   done        out  1     one-cycle pulse after last instruction of last pass
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, pc=0, instruction=IDLE_INSTR, instr_valid=0,
//   done=0, len_q=0, pass_q=0. Program store contents are not reset.
// - States: IDLE, RUN, DONE. All outputs registered except busy (decoded from state reg).
// - Priority each edge: abort > pause > normal progress.
// - IDLE
//   - load_en=1: mem[load_addr] <= load_data.
//   - start=1 and prog_len!=0: state<=RUN, pc<=0, pass_q<=repeat_cnt,
//     len_q<=min(prog_len, DEPTH).
//   - start with prog_len==0 is ignored; load and start in the same cycle are both honoured.
//     The written word is fetchable on the first RUN cycle.
// - RUN, pause=0
//   - instruction<=mem[pc], instr_valid<=1.
//   - pc!=len_q-1: pc<=pc+1.
//   - pc==len_q-1 and pass_q!=0: pc<=0, pass_q<=pass_q-1 (no bubble between passes).
//   - pc==len_q-1 and pass_q==0: state<=DONE.
//   - Latency: start sampled at edge k; first instr_valid after edge k+1;
//     N=len_q*(repeat_cnt+1) consecutive valid cycles absent pause.
// - RUN, pause=1: instr_valid<=0, instruction<=IDLE_INSTR; pc, pass_q, state hold.
//   Resume continues at held pc with no skipped or duplicated instruction.
// - DONE: instr_valid<=0, instruction<=IDLE_INSTR, done<=1, state<=IDLE.
//   done is high exactly the cycle after the last valid cycle.
// - abort=1 in any state: state<=IDLE, instr_valid<=0, instruction<=IDLE_INSTR, pc<=0, done<=0.
// - Ignored inputs:
//   - load_en, start and prog_len/repeat_cnt changes while busy are ignored.
//   - pause in IDLE/DONE has no effect.
// - done deasserts to 0 on every cycle other than the DONE-exit cycle.
// - Async reset mid-RUN: outputs drop immediately to reset values. Next start replays from pc=0.
// STRUCTURE
//   - Shared package cpu_pkg: instruction width (9), opcode localparams
//     (LOADS=2'b00, OUTR=2'b01, LOADD2=2'b10, LOADD=2'b11), seq state enum {IDLE,RUN,DONE}.
//   - One sub-module: seq_prog_ram.
//     - DEPTH x IW array; synchronous write, combinational read.
//     - Inferred as distributed RAM.
//   - FSM, pc/pass counters and output registers live in the top.
// TESTING
//   1. Load mem[0..2]=9'h0A1,9'h1C2,9'h183; prog_len=3, repeat_cnt=0, start
//      -> valid 3 cycles with 0A1,1C2,183; done the next cycle; busy then 0.
//   2. Same program, repeat_cnt=1
//      -> 6 back-to-back valid cycles: 0A1,1C2,183,0A1,1C2,183; single done pulse.
//   3. Pause high 2 cycles after first instruction
//      -> 2 invalid cycles with instruction=000; resume with 1C2; pc held at 1 during pause.
//   4. Abort on second valid cycle -> next cycle valid=0, busy=0, pc=0, no done ever.
//   5. start with prog_len=0 -> stays IDLE, busy=0.
//      prog_len=40 with DEPTH=32 -> exactly 32 valid cycles.
//   6. rst_n low mid-RUN (asynchronous, between edges)
//      -> valid/done/busy 0 immediately; fresh start replays from mem[0].

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU instruction constants and sequencer state type
package cpu_pkg;

  localparam int INSTR_W = 9;

  localparam logic [1:0] LOADS  = 2'b00;
  localparam logic [1:0] OUTR   = 2'b01;
  localparam logic [1:0] LOADD2 = 2'b10;
  localparam logic [1:0] LOADD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/seq_prog_ram.sv
// rtl/seq_prog_ram.sv - program store, synchronous write and combinational read
module seq_prog_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int IW    = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  // no reset so the array maps onto distributed RAM
  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_instr_sequencer.sv
// rtl/cpu_instr_sequencer.sv - issues a stored program to the vector CPU, repeated N times
module cpu_instr_sequencer
  import cpu_pkg::*;
#(
  parameter int            DEPTH      = 32,
  parameter int            AW         = 5,
  parameter int            IW         = INSTR_W,
  parameter logic [IW-1:0] IDLE_INSTR = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic [AW:0]   prog_len,
  input  logic [7:0]    repeat_cnt,
  input  logic          start,
  input  logic          pause,
  input  logic          abort,
  output logic [IW-1:0] instruction,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [7:0]    pass_q, pass_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          ram_we;
  logic [IW-1:0] ram_rdata;
  logic          at_last;

  seq_prog_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .IW    (IW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_q),
    .rdata (ram_rdata)
  );

  assign at_last = ({1'b0, pc_q} == (len_q - 1'b1));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    pass_d  = pass_q;
    instr_d = IDLE_INSTR;
    valid_d = 1'b0;
    done_d  = 1'b0;
    ram_we  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      pc_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          ram_we = load_en;
          if (start && (prog_len != '0)) begin
            state_d = RUN;
            pc_d    = '0;
            pass_d  = repeat_cnt;
            len_d   = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
          end
        end
        RUN: begin
          if (!pause) begin
            instr_d = ram_rdata;
            valid_d = 1'b1;
            if (!at_last) begin
              pc_d = pc_q + 1'b1;
            end else if (pass_q != '0) begin
              // wrap straight into the next pass without a bubble
              pc_d   = '0;
              pass_d = pass_q - 1'b1;
            end else begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      pass_q  <= '0;
      instr_q <= IDLE_INSTR;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      pass_q  <= pass_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// tb/tb_cpu_instr_sequencer.sv - self-checking bench for cpu_instr_sequencer
module tb_cpu_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_en;
  logic [4:0] load_addr;
  logic [8:0] load_data;
  logic [5:0] prog_len;
  logic [7:0] repeat_cnt;
  logic       start, pause, abort;
  logic [8:0] instruction;
  logic       instr_valid;
  logic [4:0] pc;
  logic       busy, done;

  int n_vec = 0;
  int n_bad = 0;

  cpu_instr_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .prog_len    (prog_len),
    .repeat_cnt  (repeat_cnt),
    .start       (start),
    .pause       (pause),
    .abort       (abort),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the program is expanded into a queue of instructions at start,
  // then one entry is consumed per unpaused cycle.
  logic [8:0] mem_m [32];
  logic [8:0] q [$];
  int         len_m = 1;
  int         total_m = 0;
  bit         active = 0;
  bit         fin = 0;
  logic [8:0] e_instr = '0;
  logic       e_valid = 1'b0;
  logic [4:0] e_pc = '0;
  logic       e_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_instr = '0; e_valid = 0; e_pc = '0; e_done = 0;
      active = 0; fin = 0; q.delete();
    end else begin
      e_done = 0;
      if (abort) begin
        q.delete(); active = 0; fin = 0;
        e_valid = 0; e_instr = '0; e_pc = '0;
      end else if (!active) begin
        e_valid = 0; e_instr = '0;
        if (load_en) mem_m[load_addr] = load_data;
        if (start && prog_len != 0) begin
          len_m = (prog_len > 32) ? 32 : int'(prog_len);
          for (int p = 0; p <= int'(repeat_cnt); p++)
            for (int i = 0; i < len_m; i++) q.push_back(mem_m[i]);
          total_m = q.size();
          active = 1;
          e_pc = '0;
        end
      end else if (fin) begin
        e_valid = 0; e_instr = '0; e_done = 1; active = 0; fin = 0;
      end else if (pause) begin
        e_valid = 0; e_instr = '0;
      end else begin
        e_instr = q.pop_front();
        e_valid = 1;
        if (q.size() == 0) fin = 1;
        else e_pc = 5'((total_m - q.size()) % len_m);
      end
    end
  end

  bit chk_on = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      chk("instruction", 32'(instruction), 32'(e_instr));
      chk("instr_valid", 32'(instr_valid), 32'(e_valid));
      chk("pc", 32'(pc), 32'(e_pc));
      chk("busy", 32'(busy), 32'(active));
      chk("done", 32'(done), 32'(e_done));
    end
  end

  logic [8:0] got [$];
  int         ndone = 0;
  always @(negedge clk) begin
    if (rst_n && instr_valid) got.push_back(instruction);
    if (rst_n && done) ndone++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input logic [4:0] a, input logic [8:0] d);
    load_en = 1; load_addr = a; load_data = d;
    tick();
    load_en = 0;
  endtask

  task automatic go(input logic [5:0] len, input logic [7:0] rep);
    prog_len = len; repeat_cnt = rep; start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy) return;
    end
    n_vec++; n_bad++;
    $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", budget);
  endtask

  task automatic clear_obs();
    got.delete();
    ndone = 0;
  endtask

  initial begin
    rst_n = 0; load_en = 0; load_addr = '0; load_data = '0;
    prog_len = '0; repeat_cnt = '0; start = 0; pause = 0; abort = 0;
    repeat (2) tick();
    chk("reset valid", 32'(instr_valid), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset pc", 32'(pc), 0);
    chk("reset instruction", 32'(instruction), 0);
    rst_n = 1;
    chk_on = 1;

    // 1: single pass
    load(5'd0, 9'h0A1); load(5'd1, 9'h1C2); load(5'd2, 9'h183);
    clear_obs();
    go(6'd3, 8'd0);
    wait_idle(20); tick();
    chk("t1 count", 32'(got.size()), 3);
    if (got.size() == 3) begin
      chk("t1 i0", 32'(got[0]), 32'h0A1);
      chk("t1 i1", 32'(got[1]), 32'h1C2);
      chk("t1 i2", 32'(got[2]), 32'h183);
    end
    chk("t1 done pulses", 32'(ndone), 1);

    // 2: two passes back to back
    clear_obs();
    go(6'd3, 8'd1);
    wait_idle(20); tick();
    chk("t2 count", 32'(got.size()), 6);
    if (got.size() == 6) begin
      chk("t2 i3", 32'(got[3]), 32'h0A1);
      chk("t2 i5", 32'(got[5]), 32'h183);
    end
    chk("t2 done pulses", 32'(ndone), 1);

    // 3: pause for two cycles after the first instruction
    clear_obs();
    go(6'd3, 8'd0);
    tick();
    pause = 1;
    tick();
    chk("t3 pause valid", 32'(instr_valid), 0);
    chk("t3 pause instr", 32'(instruction), 0);
    chk("t3 pause pc", 32'(pc), 1);
    tick();
    chk("t3 pause pc 2", 32'(pc), 1);
    pause = 0;
    wait_idle(20); tick();
    chk("t3 count", 32'(got.size()), 3);
    if (got.size() == 3) chk("t3 resume", 32'(got[1]), 32'h1C2);
    chk("t3 done pulses", 32'(ndone), 1);

    // 4: abort on the second valid cycle
    clear_obs();
    go(6'd3, 8'd0);
    tick(); tick();
    abort = 1;
    tick();
    abort = 0;
    chk("t4 valid", 32'(instr_valid), 0);
    chk("t4 busy", 32'(busy), 0);
    chk("t4 pc", 32'(pc), 0);
    repeat (4) tick();
    chk("t4 done pulses", 32'(ndone), 0);
    chk("t4 count", 32'(got.size()), 2);

    // 5a: zero length start is ignored
    go(6'd0, 8'd0);
    chk("t5 zero len busy", 32'(busy), 0);
    tick();

    // 6: asynchronous reset between edges
    clear_obs();
    go(6'd3, 8'd1);
    tick(); tick();
    #2 rst_n = 0;
    #1;
    chk("t6 valid", 32'(instr_valid), 0);
    chk("t6 busy", 32'(busy), 0);
    chk("t6 done", 32'(done), 0);
    chk("t6 pc", 32'(pc), 0);
    tick();
    rst_n = 1;
    tick();
    clear_obs();
    go(6'd3, 8'd0);
    wait_idle(20); tick();
    chk("t6 replay count", 32'(got.size()), 3);
    if (got.size() == 3) chk("t6 replay first", 32'(got[0]), 32'h0A1);

    // 5b: length above depth clamps to 32
    for (int i = 0; i < 32; i++) load(5'(i), 9'((i * 37 + 5) & 9'h1FF));
    clear_obs();
    go(6'd40, 8'd0);
    wait_idle(60); tick();
    chk("t5 clamp count", 32'(got.size()), 32);
    if (got.size() == 32) chk("t5 last", 32'(got[31]), 32'h080);
    chk("t5 done pulses", 32'(ndone), 1);

    // load and start in the same cycle, single-instruction program
    clear_obs();
    load_en = 1; load_addr = 5'd0; load_data = 9'h155;
    go(6'd1, 8'd2);
    load_en = 0;
    wait_idle(20); tick();
    chk("t7 count", 32'(got.size()), 3);
    if (got.size() == 3) chk("t7 word", 32'(got[2]), 32'h155);
    chk("t7 done pulses", 32'(ndone), 1);

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
